// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_pkg;

  localparam int         NUM_REGS = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries with a registered not-full (ready) flag.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t pop_entry,
  output logic      empty,
  output logic      ready
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;

  always_comb begin
    count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      ready <= (count_next != (AW+1)'(DEPTH));
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign empty     = (count == '0);
  assign pop_entry = mem[rd_ptr];

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges ALU and load results onto the register-file write port with a pending-write scoreboard.
// Optional statistics outputs are enabled by defining WB_ARB_STATS_EN.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int BUF_DEPTH    = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_rd,
  output logic        rsv_ready,
  output logic [31:0] busy,
  output logic        wen,
  output logic [4:0]  wsel,
  output logic [31:0] wdata
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0] stat_alu_wr,
  output logic [31:0] stat_ld_wr,
  output logic [31:0] stat_stall
`endif
);

  localparam int               SW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic      alu_push, ld_push, alu_pop, ld_pop, alu_empty, ld_empty;
  wb_entry_t alu_head, ld_head, pop_entry;
  logic [SW-1:0] starve;

  // Writes to r0 are swallowed at the input: accepted but never queued.
  assign alu_push = alu_valid && alu_ready && (alu_rd != REG_ZERO);
  assign ld_push  = ld_valid && ld_ready && (ld_rd != REG_ZERO);

  wb_fifo #(.DEPTH(BUF_DEPTH)) u_alu_fifo (
    .clk(clk), .rst(rst), .push(alu_push), .push_entry('{rd: alu_rd, data: alu_data}),
    .pop(alu_pop), .pop_entry(alu_head), .empty(alu_empty), .ready(alu_ready)
  );

  wb_fifo #(.DEPTH(BUF_DEPTH)) u_ld_fifo (
    .clk(clk), .rst(rst), .push(ld_push), .push_entry('{rd: ld_rd, data: ld_data}),
    .pop(ld_pop), .pop_entry(ld_head), .empty(ld_empty), .ready(ld_ready)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    alu_pop = 1'b0;
    ld_pop  = 1'b0;
    if (!alu_empty && !ld_empty) begin
      if (starve == SW'(STARVE_LIMIT)) alu_pop = 1'b1;
      else                             ld_pop  = 1'b1;
    end else if (!alu_empty) begin
      alu_pop = 1'b1;
    end else if (!ld_empty) begin
      ld_pop = 1'b1;
    end
    pop_entry = alu_pop ? alu_head : ld_head;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
      wen    <= 1'b0;
      wsel   <= '0;
      wdata  <= '0;
    end else begin
      wen <= alu_pop || ld_pop;
      if (alu_pop || ld_pop) begin
        wsel  <= pop_entry.rd;
        wdata <= pop_entry.data;
      end
      if (alu_pop)                    starve <= '0;
      else if (ld_pop && !alu_empty)  starve <= starve + SW'(1);
    end
  end

  // Scoreboard: one outstanding-write counter per architectural register.
  logic [CNT_W-1:0] cnt      [NUM_REGS];
  logic [CNT_W-1:0] cnt_next [NUM_REGS];
  logic             rsv_fire;

  assign rsv_ready = (rsv_rd == REG_ZERO) || (cnt[rsv_rd] != CNT_MAX);
  assign rsv_fire  = rsv_valid && rsv_ready && (rsv_rd != REG_ZERO);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      logic inc, dec;
      inc         = rsv_fire && (rsv_rd == 5'(i));
      dec         = wen && (wsel == 5'(i));
      cnt_next[i] = cnt[i];
      if (inc && !dec)                        cnt_next[i] = cnt[i] + CNT_W'(1);
      else if (dec && !inc && cnt[i] != '0)   cnt_next[i] = cnt[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      busy <= '0;
    end else begin
      cnt <= cnt_next;
      for (int i = 0; i < NUM_REGS; i++) busy[i] <= (cnt_next[i] != '0);
    end
  end

  // A retire with nothing outstanding means the issue stage skipped its reservation.
  always_ff @(posedge clk) begin
    if (!rst && wen) assert (cnt[wsel] != '0);
  end

`ifdef WB_ARB_STATS_EN
  wb_src_e src_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q       <= SRC_ALU;
      stat_alu_wr <= '0;
      stat_ld_wr  <= '0;
      stat_stall  <= '0;
    end else begin
      if (alu_pop || ld_pop) src_q <= alu_pop ? SRC_ALU : SRC_LD;
      if (wen && src_q == SRC_ALU) stat_alu_wr <= stat_alu_wr + 32'd1;
      if (wen && src_q == SRC_LD)  stat_ld_wr  <= stat_ld_wr + 32'd1;
      if ((alu_valid && !alu_ready) || (ld_valid && !ld_ready))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter with hand-computed expectations.
module tb_wb_write_arbiter;

  logic        clk, rst;
  logic        alu_valid, alu_ready, ld_valid, ld_ready, rsv_valid, rsv_ready, wen;
  logic [4:0]  alu_rd, ld_rd, rsv_rd, wsel;
  logic [31:0] alu_data, ld_data, busy, wdata;
`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_alu_wr, stat_ld_wr, stat_stall;
`endif

  int tests = 0;
  int fails = 0;
  int alu_n, ld_n;
  logic a_acc, l_acc;
  logic [4:0]  log_rd   [$];
  logic [31:0] log_data [$];
  int exp_pri [8] = '{11, 12, 13, 1, 14, 2, 3, 4};
  int exp_bp  [9] = '{26, 27, 28, 21, 29, 22, 23, 24, 25};

  wb_write_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_ready(rsv_ready), .busy(busy),
    .wen(wen), .wsel(wsel), .wdata(wdata)
`ifdef WB_ARB_STATS_EN
    , .stat_alu_wr(stat_alu_wr), .stat_ld_wr(stat_ld_wr), .stat_stall(stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Retirement log, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && wen) begin
      log_rd.push_back(wsel);
      log_data.push_back(wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reserve(input logic [4:0] r);
    rsv_valid = 1'b1;
    rsv_rd    = r;
    step();
    rsv_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_rd.delete();
    log_data.delete();
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0;
    rsv_valid = 1'b0; rsv_rd = '0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_wen", wen, 0);
    check("rst_wsel", wsel, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_ready", alu_ready, 1);
    check("rst_ld_ready", ld_ready, 1);

    // Single ALU write with 2-edge latency.
    reserve(5'd5);
    check("t1_busy5_set", busy[5], 1);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    step();
    alu_valid = 1'b0;
    check("t1_wen_e1", wen, 0);
    step();
    check("t1_wen_e2", wen, 1);
    check("t1_wsel", wsel, 5);
    check("t1_wdata", wdata, 32'h1234);
    step();
    check("t1_wen_low", wen, 0);
    check("t1_wdata_hold", wdata, 32'h1234);
    check("t1_busy5_clr", busy[5], 0);

    // Priority and starvation guard.
    for (int k = 1; k <= 4; k++) begin
      reserve(5'(k));
      reserve(5'(10 + k));
    end
    clear_log();
    for (int k = 1; k <= 4; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(k);      alu_data = 32'h100 + k;
      ld_valid  = 1'b1; ld_rd  = 5'(10 + k); ld_data  = 32'h100 + 10 + k;
      step();
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    repeat (8) step();
    check("pri_count", log_rd.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_rd.size()) begin
        check($sformatf("pri_rd%0d", i), log_rd[i], exp_pri[i]);
        check($sformatf("pri_data%0d", i), log_data[i], 32'h100 + exp_pri[i]);
      end
    end
    check("pri_busy", busy, 0);

    // Backpressure: ALU loses to loads until its FIFO fills.
    for (int k = 21; k <= 29; k++) reserve(5'(k));
    clear_log();
    alu_n = 0; ld_n = 0;
    for (int c = 0; c < 20 && alu_n < 5; c++) begin
      alu_valid = 1'b1; alu_rd = 5'(21 + alu_n); alu_data = 32'h200 + 21 + alu_n;
      ld_valid  = (ld_n < 4); ld_rd = 5'(26 + ld_n); ld_data = 32'h200 + 26 + ld_n;
      a_acc = alu_ready;
      l_acc = ld_valid && ld_ready;
      step();
      if (a_acc) alu_n++;
      if (l_acc) ld_n++;
      if (a_acc && alu_n == 4) check("bp_ready_low", alu_ready, 0);
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    check("bp_alu_accepts", alu_n, 5);
    repeat (10) step();
    check("bp_count", log_rd.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < log_rd.size()) begin
        check($sformatf("bp_rd%0d", i), log_rd[i], exp_bp[i]);
        check($sformatf("bp_data%0d", i), log_data[i], 32'h200 + exp_bp[i]);
      end
    end
    check("bp_busy", busy, 0);

    // rd=0 entries are accepted and dropped.
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFF;
    check("rd0_ready", ld_ready, 1);
    step();
    ld_valid = 1'b0;
    clear_log();
    repeat (3) step();
    check("rd0_no_write", log_rd.size(), 0);
    check("rd0_busy", busy, 0);

    // Scoreboard saturation, retire, and same-edge reserve+retire.
    rsv_valid = 1'b1; rsv_rd = 5'd7;
    step();
    check("sb_busy7_1", busy[7], 1);
    check("sb_rsv_ready_1", rsv_ready, 1);
    step();
    step();
    check("sb_rsv_ready_full", rsv_ready, 0);
    step();
    rsv_valid = 1'b0; rsv_rd = 5'd0;
    #1;
    check("sb_rsv_ready_r0", rsv_ready, 1);
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h700 + k;
      step();
    end
    alu_valid = 1'b0;
    step();
    check("sb_busy7_one_left", busy[7], 1);
    step();
    check("sb_busy7_clr", busy[7], 0);
    reserve(5'd7);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h777;
    step();
    alu_valid = 1'b0;
    step();
    check("sb_same_wen", wen, 1);
    check("sb_same_wsel", wsel, 7);
    rsv_valid = 1'b1; rsv_rd = 5'd7;
    step();
    rsv_valid = 1'b0;
    check("sb_same_busy7", busy[7], 1);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h778;
    step();
    alu_valid = 1'b0;
    repeat (2) step();
    check("sb_final_busy", busy, 0);

    // Reset with entries queued.
    reserve(5'd1); reserve(5'd2); reserve(5'd11); reserve(5'd12);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h51;
    ld_valid  = 1'b1; ld_rd  = 5'd11; ld_data = 32'h5B;
    step();
    alu_rd = 5'd2; alu_data = 32'h52; ld_rd = 5'd12; ld_data = 32'h5C;
    step();
    alu_valid = 1'b0; ld_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_wen", wen, 0);
    check("mrst_busy", busy, 0);
    check("mrst_alu_ready", alu_ready, 1);
    check("mrst_ld_ready", ld_ready, 1);
    clear_log();
    repeat (5) step();
    check("mrst_no_write", log_rd.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Write-side front end of the core register file. It merges result streams from the ALU and the load unit into the register file's single write port, driving wen/wsel/wdata.
- Each source has a valid/ready handshake and a small input FIFO. Arbitration uses fixed priority with a starvation guard.
- A per-register pending scoreboard lets the issue stage reserve destinations and see which registers are busy until their writeback retires.

Parameters:
- BUF_DEPTH, 4, entries per source FIFO (power of two, at least 2).
- STARVE_LIMIT, 3, consecutive lost arbitrations after which the ALU wins.
- CNT_W, 2, width of each per-register outstanding-write counter.

Ports:
- clk  in  1  core clock, rising-edge logic.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU FIFO not full.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ld_valid  in  1  load result valid.
- ld_ready  out  1  load FIFO not full.
- ld_rd  in  5  load destination register.
- ld_data  in  32  load data.
- rsv_valid  in  1  issue stage reserves rsv_rd.
- rsv_rd  in  5  register being reserved.
- rsv_ready  out  1  rsv_rd counter below max.
- busy  out  32  bit i set while cnt[i] != 0; bit 0 is always 0.
- wen  out  1  register-file write enable.
- wsel  out  5  register-file write select.
- wdata  out  32  register-file write data.

Behaviour:
- Reset:
  - Both FIFOs are emptied and all counters cleared.
  - wen=0, wsel=0, wdata=0, busy=0.
  - alu_ready and ld_ready are high in the cycle after reset.
  - The starvation counter is cleared.
  - Reset asserted mid-operation discards all queued entries with no write.
- Handshake:
  - A source is accepted on a rising edge when valid and ready are both high.
  - ready = FIFO not full, registered. ready does not depend combinationally on valid.
  - Entries with rd=0 are accepted and discarded: never enqueued, no counter effect.
- Pop and arbitration:
  - At most one entry is popped per edge.
  - If both FIFOs are non-empty, the load FIFO wins unless the ALU starvation count equals STARVE_LIMIT. In that case the ALU wins and the starvation count clears.
  - The starvation count increments each edge the ALU loses with its FIFO non-empty. It clears whenever the ALU pops.
- Output timing:
  - wen/wsel/wdata are registered from the popped entry.
  - An entry accepted at edge E pops no earlier than edge E+1, so wen is high during the cycle after E+1 (2-edge latency).
  - wen is low in any cycle following an edge with no pop.
  - wdata/wsel hold their last values when wen is low.
- Full/empty:
  - A push and a pop in the same edge on a full FIFO leaves it full. ready stays low that cycle; the push is legal only if ready was high.
  - FIFO pointers wrap modulo BUF_DEPTH.
- Scoreboard:
  - cnt[rsv_rd]++ on an edge with rsv_valid && rsv_ready && rsv_rd != 0.
  - cnt[wsel]-- on each edge where wen is high (retire).
  - If a reserve and a retire hit the same register on the same edge, the count is unchanged.
  - rsv_ready is combinational: cnt[rsv_rd] != 2^CNT_W - 1, or rsv_rd == 0.
  - A retire on a register whose cnt is 0 leaves it at 0; this is a protocol error, asserted in simulation.
  - busy is registered from the counters.
- Ordering: writes from one source retire in acceptance order. No ordering is guaranteed between sources.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- When defined, adds outputs stat_alu_wr (32), stat_ld_wr (32), and stat_stall (32):
  - stat_alu_wr and stat_ld_wr count retired writes per source.
  - stat_stall counts cycles in which any source has valid high and ready low.
  - All three wrap at 2^32 and clear on rst.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Package wb_pkg holds:
  - wb_entry_t struct {rd[4:0], data[31:0]}.
  - Source enum {SRC_ALU, SRC_LD}.
  - Constants NUM_REGS=32 and REG_ZERO=5'd0.
- One sub-module, wb_fifo (parameterised sync FIFO of wb_entry_t), instantiated once per source.

Test Plan:
- Single write: alu_valid with rd=5, data=0x1234 accepted at edge 1 → wen=1, wsel=5, wdata=0x1234 in the cycle after edge 2; wen=0 next cycle.
- Priority and starvation: both FIFOs pre-filled with 4 entries each (ALU rd=1..4, load rd=11..14) → retire order 11,12,13,1,14,2,3,4.
- Backpressure: 5 back-to-back ALU pushes with the output popping → alu_ready drops after the fourth accept; no entry is lost or duplicated.
- rd=0 drop: ld push with rd=0, data=0xFFFF → accepted (ld_ready high), wen never asserted, busy unchanged.
- Scoreboard: reserve rd=7 three times → busy[7]=1 and rsv_ready low for rd=7; the fourth reserve is blocked. Three retires to rd=7 → busy[7]=0. A reserve plus retire of rd=7 on the same edge → cnt unchanged.
- Reset mid-stream: rst with 3 entries queued → no further wen, busy=0, both readies high in the cycle after reset.
